// File: rtl/options_parse_sched.sv
// Round-robin arbiter that lends one options parser to NUM_REQ header requesters,
// tracks the parse to done or timeout and hands the result back to the owner.
module options_parse_sched #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 6,
    parameter int MAX_LEN = 40,
    parameter int RES_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [RES_W-1:0]         rsp_result,
    output logic                     rsp_err,
    input  logic                     par_ready,
    output logic                     par_start,
    output logic [LEN_W-1:0]         par_len,
    input  logic                     par_done,
    input  logic [RES_W-1:0]         par_result,
    output logic                     par_abort
);

    // state | meaning
    // IDLE  | arbitrate, accept one request, screen its length
    // ISSUE | hold par_len, pulse par_start once the parser is ready
    // BUSY  | wait for par_done, abort when the timeout budget runs out
    // RESP  | present result to the owner until it takes it
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = GW + 1;

    logic [1:0]       state;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    grant;
    logic [LEN_W-1:0] len_q;
    logic [RES_W-1:0] result_q;
    logic             err_q;
    logic [TO_W-1:0]  tmr;

    logic [LEN_W-1:0] len_arr [NUM_REQ];
    logic             win_found;
    logic [GW-1:0]    win_idx;
    logic [LEN_W-1:0] win_len;
    logic [SW-1:0]    sum;
    logic             timed_out;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            len_arr[i] = req_len[i*LEN_W +: LEN_W];
        end
    end

    // Scan starts one past the previous owner so everyone gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_grant} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            if (!win_found && req_valid[sum[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[GW-1:0];
            end
        end
    end

    assign win_len = len_arr[win_idx];

    // Down-counter loaded at start; reaching zero marks TIMEOUT cycles since par_start.
    assign timed_out = (tmr == '0);

    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && !rst) begin
            req_ready = NUM_REQ'(1) << win_idx;
        end
    end

    assign rsp_valid  = (state == RESP) ? (NUM_REQ'(1) << grant) : '0;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign par_len    = len_q;
    assign par_start  = (state == ISSUE) && par_ready && !rst;
    assign par_abort  = (state == BUSY) && !par_done && timed_out && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant      <= '0;
            len_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            tmr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant <= win_idx;
                        len_q <= win_len;
                        if (win_len == '0) begin
                            result_q <= '0;
                            err_q    <= 1'b0;
                            state    <= RESP;
                        end else if (win_len > LEN_W'(MAX_LEN)) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                            state    <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (par_ready) begin
                        tmr   <= TO_W'(TIMEOUT - 1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (par_done) begin
                        result_q <= par_result;
                        err_q    <= 1'b0;
                        state    <= RESP;
                    end else if (timed_out) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        state    <= RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_options_parse_sched.sv
// Self-checking bench for options_parse_sched: directed transaction table, reset
// sequences and randomized transactions predicted by a round-robin reference model.
module tb_options_parse_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_len;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        par_ready;
    logic        par_start;
    logic [5:0]  par_len;
    logic        par_done;
    logic [31:0] par_result;
    logic        par_abort;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    options_parse_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .par_ready(par_ready), .par_start(par_start), .par_len(par_len),
        .par_done(par_done), .par_result(par_result), .par_abort(par_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [5:0]  len;
        int          delay;       // cycles from par_start to par_done, -1 = never
        int          ready_hold;  // ISSUE cycles with par_ready low
        int          rsp_hold;    // extra RESP cycles before owner accepts
        logic [31:0] res;
        logic [3:0]  exp_grant;
        logic        exp_err;
        logic [31:0] exp_res;
        int          exp_starts;
        int          exp_aborts;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic inv();
        chk("onehot_req_ready", 64'($countones(req_ready) <= 1), 64'd1);
        chk("onehot_rsp_valid", 64'($countones(rsp_valid) <= 1), 64'd1);
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [3:0] valid, input logic [23:0] lens, input int delay,
                           input int ready_hold, input int rsp_hold, input logic [31:0] res,
                           input logic [3:0] exp_grant, input logic [5:0] exp_len,
                           input logic exp_err, input logic [31:0] exp_res,
                           input int exp_starts, input int exp_aborts);
        int accept_cyc, start_cyc, done_cyc, abort_cyc, resp_cyc;
        int n_start, n_abort, unstable, budget, exp_resp;
        bit resp_seen, finished, done_drv;
        logic [3:0]  r_mask;
        logic [31:0] r_res;
        logic        r_err;
        start_cyc = 0; done_cyc = 0; abort_cyc = 0; resp_cyc = 0;
        n_start = 0; n_abort = 0; unstable = 0; budget = 0;
        resp_seen = 0; finished = 0; done_drv = 0;
        r_mask = '0; r_res = '0; r_err = 1'b0;

        tick();
        req_valid  = valid;
        req_len    = lens;
        par_ready  = (ready_hold == 0);
        rsp_ready  = ~exp_grant;
        par_done   = 1'b0;
        par_result = $urandom;
        #1;
        inv();
        chk("accept_grant", 64'(req_ready), 64'(exp_grant));
        chk("no_start_in_idle", 64'(par_start), 64'd0);
        accept_cyc = cyc;

        while (!finished && budget < 1000) begin
            tick();
            budget++;
            req_valid  = '0;
            par_ready  = (cyc > accept_cyc + ready_hold);
            done_drv   = (n_start > 0 && delay >= 0 && cyc == start_cyc + delay);
            par_done   = done_drv;
            par_result = done_drv ? res : $urandom;
            #1;
            inv();
            if (done_drv) done_cyc = cyc;
            if (par_start) begin
                n_start++;
                if (n_start == 1) begin
                    start_cyc = cyc;
                    chk("par_len", 64'(par_len), 64'(exp_len));
                end
            end
            if (par_abort) begin
                n_abort++;
                abort_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                if (!resp_seen) begin
                    resp_seen = 1;
                    resp_cyc  = cyc;
                    r_mask    = rsp_valid;
                    r_res     = rsp_result;
                    r_err     = rsp_err;
                end else if (rsp_valid !== r_mask || rsp_result !== r_res || rsp_err !== r_err) begin
                    unstable++;
                end
            end else if (resp_seen) begin
                finished = 1;
            end
            rsp_ready = (resp_seen && !finished && cyc >= resp_cyc + rsp_hold) ? 4'hF : ~exp_grant;
        end

        chk("txn_complete", 64'(finished), 64'd1);
        chk("start_count", 64'(n_start), 64'(exp_starts));
        if (exp_starts == 1 && n_start == 1)
            chk("start_latency", 64'(start_cyc - accept_cyc), 64'(1 + ready_hold));
        chk("abort_count", 64'(n_abort), 64'(exp_aborts));
        if (exp_aborts == 1 && n_abort == 1)
            chk("abort_latency", 64'(abort_cyc - start_cyc), 64'd255);
        chk("rsp_valid", 64'(r_mask), 64'(exp_grant));
        chk("rsp_result", 64'(r_res), 64'(exp_res));
        chk("rsp_err", 64'(r_err), 64'(exp_err));
        chk("rsp_stable", 64'(unstable), 64'd0);
        if (exp_aborts == 1)      exp_resp = abort_cyc + 1;
        else if (exp_starts == 1) exp_resp = done_cyc + 1;
        else                      exp_resp = accept_cyc + 1;
        chk("rsp_latency", 64'(resp_cyc), 64'(exp_resp));
        if (finished) chk("rsp_drop", 64'(cyc - resp_cyc), 64'(rsp_hold + 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_len = '0; rsp_ready = '0;
        par_ready = 1'b0; par_done = 1'b0; par_result = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] lens;
        logic [5:0]  wl;
        logic [3:0]  mask;
        logic [31:0] res, eres;
        int last, g, dly, es, ea, r;
        logic        eerr;

        //           valid  len  dly  rh  sh  res      grant  err  exp_res  st ab
        vecs[0]  = '{4'h1, 6'd12,   5,  0,  0, 32'hA5, 4'h1, 1'b0, 32'hA5, 1, 0};
        vecs[1]  = '{4'hF, 6'd8,    3,  0,  0, 32'h11, 4'h2, 1'b0, 32'h11, 1, 0};
        vecs[2]  = '{4'hF, 6'd8,    3,  0,  0, 32'h22, 4'h4, 1'b0, 32'h22, 1, 0};
        vecs[3]  = '{4'hF, 6'd8,    3,  0,  0, 32'h33, 4'h8, 1'b0, 32'h33, 1, 0};
        vecs[4]  = '{4'hF, 6'd8,    3,  0,  0, 32'h44, 4'h1, 1'b0, 32'h44, 1, 0};
        vecs[5]  = '{4'h4, 6'd0,    3,  0,  0, 32'h55, 4'h4, 1'b0, 32'h0,  0, 0};
        vecs[6]  = '{4'h8, 6'd41,   3,  0,  0, 32'h66, 4'h8, 1'b1, 32'h0,  0, 0};
        vecs[7]  = '{4'h1, 6'd8,   -1,  0,  0, 32'h77, 4'h1, 1'b1, 32'h0,  1, 1};
        vecs[8]  = '{4'h2, 6'd20,   4, 10,  0, 32'h88, 4'h2, 1'b0, 32'h88, 1, 0};
        vecs[9]  = '{4'h4, 6'd8,  255,  0,  0, 32'h99, 4'h4, 1'b0, 32'h99, 1, 0};
        vecs[10] = '{4'h8, 6'd40,   2,  0,  6, 32'hAA, 4'h8, 1'b0, 32'hAA, 1, 0};
        vecs[11] = '{4'h3, 6'd63,   2,  0,  0, 32'hBB, 4'h1, 1'b1, 32'h0,  0, 0};
        vecs[12] = '{4'h3, 6'd1,    2,  0,  0, 32'hCC, 4'h2, 1'b0, 32'hCC, 1, 0};
        vecs[13] = '{4'h9, 6'd8,    1,  0,  2, 32'hDD, 4'h8, 1'b0, 32'hDD, 1, 0};

        do_reset();
        #1;
        chk("reset_outputs", {15'd0, req_ready, rsp_valid, rsp_result, rsp_err, par_start, par_len, par_abort}, 64'd0);

        // zero-length request present through reset: accepted on release, answered next cycle
        rst = 1'b1; req_valid = 4'h4; req_len = '0;
        tick(); #1;
        chk("req_ready_in_reset", 64'(req_ready), 64'd0);
        tick(); rst = 1'b0; #1;
        chk("len0_accept", 64'(req_ready), 64'h4);
        tick(); req_valid = '0; #1;
        chk("len0_rsp_valid", 64'(rsp_valid), 64'h4);
        chk("len0_result", {31'd0, rsp_err, rsp_result}, 64'd0);
        chk("len0_no_start", 64'(par_start), 64'd0);
        rsp_ready = 4'hF;
        tick(); #1;
        chk("len0_rsp_drop", 64'(rsp_valid), 64'd0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].valid, {4{vecs[i].len}}, vecs[i].delay, vecs[i].ready_hold,
                    vecs[i].rsp_hold, vecs[i].res, vecs[i].exp_grant, vecs[i].len,
                    vecs[i].exp_err, vecs[i].exp_res, vecs[i].exp_starts, vecs[i].exp_aborts);
        end

        last = 3;
        for (int t = 0; t < 150; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      lens[i*6 +: 6] = 6'd0;
                else if (r == 9) lens[i*6 +: 6] = 6'($urandom_range(41, 63));
                else             lens[i*6 +: 6] = 6'($urandom_range(1, 40));
            end
            r = $urandom_range(0, 19);
            if (r == 0)      dly = -1;
            else if (r == 1) dly = 255;
            else             dly = $urandom_range(1, 15);
            res = $urandom;
            g   = rr_pick(last, mask);
            wl  = lens[g*6 +: 6];
            if (wl == 0) begin
                eerr = 1'b0; eres = '0; es = 0; ea = 0;
            end else if (wl > 40) begin
                eerr = 1'b1; eres = '0; es = 0; ea = 0;
            end else if (dly < 0) begin
                eerr = 1'b1; eres = '0; es = 1; ea = 1;
            end else begin
                eerr = 1'b0; eres = res; es = 1; ea = 0;
            end
            run_txn(mask, lens, dly, $urandom_range(0, 3), $urandom_range(0, 3), res,
                    4'(1 << g), wl, eerr, eres, es, ea);
            last = g;
        end

        // reset while the parser is busy: no abort, everything back to zero
        tick();
        req_valid = 4'h1; req_len = 24'd8; par_ready = 1'b1; rsp_ready = '0; par_done = 1'b0;
        #1;
        chk("busy_rst_accept", 64'(req_ready), 64'h1);
        tick(); req_valid = '0; #1;
        chk("busy_rst_start", 64'(par_start), 64'd1);
        repeat (3) tick();
        rst = 1'b1; #1;
        chk("busy_rst_no_abort", 64'(par_abort), 64'd0);
        tick(); rst = 1'b0; #1;
        chk("busy_rst_outputs", {15'd0, req_ready, rsp_valid, rsp_result, rsp_err, par_start, par_len, par_abort}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
